// File: rtl/nibble_burst_framer.sv
`timescale 1ns/1ps
// Purpose: collects MSB-first serial bits into a nibble buffer and replays each frame as a gap-free valid burst.
// Latency: first valid is one cycle after HOLD sees busy low; bursts are followed by two GAP cycles.
// Backpressure: sin_ready drops from frame close until the post-burst gap ends; busy only stalls HOLD.
module nibble_burst_framer #(
    parameter int MAX_NIB = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sin_valid,
    input  logic       sin_bit,
    input  logic       sin_last,
    output logic       sin_ready,
    input  logic       busy,
    output logic       valid,
    output logic [3:0] num,
    output logic       err,
    output logic [7:0] frames_sent
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_NIB);

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        HOLD,
        EMIT,
        GAP,
        DROP
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] nib_cnt, nib_cnt_nxt;
    logic [1:0] bit_cnt, bit_cnt_nxt;
    logic [3:0] asm_q, asm_nxt;
    logic [3:0] emit_idx, emit_idx_nxt;
    logic       gap_cnt, gap_cnt_nxt;
    logic       valid_nxt;
    logic [3:0] num_nxt;
    logic       err_nxt;
    logic [7:0] frames_nxt;

    // Buffer is sized for the widest legal frame so the 4-bit count indexes it directly.
    logic [3:0] buf_q [16];
    logic       wr_en;
    logic       accept;
    logic       nib_end;
    logic [3:0] nib_val;

    // The assembler is kept left-justified, so a partial nibble at frame close needs no realignment.
    assign sin_ready = (state == IDLE) || (state == COLLECT) || (state == DROP);
    assign accept    = sin_valid && sin_ready;
    assign nib_val   = asm_q | ({sin_bit, 3'b000} >> bit_cnt);
    assign nib_end   = (bit_cnt == 2'd3) || sin_last;

    // Next-state and next-output decode; every registered value defaults to holding or idling.
    always_comb begin
        state_nxt    = state;
        nib_cnt_nxt  = nib_cnt;
        bit_cnt_nxt  = bit_cnt;
        asm_nxt      = asm_q;
        emit_idx_nxt = emit_idx;
        gap_cnt_nxt  = gap_cnt;
        valid_nxt    = 1'b0;
        num_nxt      = 4'h0;
        err_nxt      = 1'b0;
        frames_nxt   = frames_sent;
        wr_en        = 1'b0;
        case (state)
            IDLE, COLLECT: begin
                if (accept) begin
                    asm_nxt     = nib_val;
                    bit_cnt_nxt = bit_cnt + 2'd1;
                    state_nxt   = COLLECT;
                    if (nib_end) begin
                        asm_nxt     = 4'h0;
                        bit_cnt_nxt = 2'd0;
                        if (nib_cnt == MAX_CNT) begin
                            // One nibble too many: throw the frame away and swallow the rest of it.
                            err_nxt     = 1'b1;
                            nib_cnt_nxt = 4'd0;
                            state_nxt   = sin_last ? IDLE : DROP;
                        end else begin
                            wr_en       = 1'b1;
                            nib_cnt_nxt = nib_cnt + 4'd1;
                            state_nxt   = sin_last ? HOLD : COLLECT;
                        end
                    end
                end
            end
            DROP: begin
                if (accept && sin_last) begin
                    state_nxt = IDLE;
                end
            end
            HOLD: begin
                if (!busy) begin
                    state_nxt    = EMIT;
                    valid_nxt    = 1'b1;
                    num_nxt      = buf_q[0];
                    emit_idx_nxt = 4'd1;
                end
            end
            EMIT: begin
                if (emit_idx == nib_cnt) begin
                    state_nxt    = GAP;
                    frames_nxt   = frames_sent + 8'd1;
                    nib_cnt_nxt  = 4'd0;
                    emit_idx_nxt = 4'd0;
                    gap_cnt_nxt  = 1'b0;
                end else begin
                    valid_nxt    = 1'b1;
                    num_nxt      = buf_q[emit_idx];
                    emit_idx_nxt = emit_idx + 4'd1;
                end
            end
            GAP: begin
                gap_cnt_nxt = 1'b1;
                if (gap_cnt) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and registered outputs; reset wins over every other input.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            nib_cnt     <= 4'd0;
            bit_cnt     <= 2'd0;
            asm_q       <= 4'h0;
            emit_idx    <= 4'd0;
            gap_cnt     <= 1'b0;
            valid       <= 1'b0;
            num         <= 4'h0;
            err         <= 1'b0;
            frames_sent <= 8'h00;
        end else begin
            state       <= state_nxt;
            nib_cnt     <= nib_cnt_nxt;
            bit_cnt     <= bit_cnt_nxt;
            asm_q       <= asm_nxt;
            emit_idx    <= emit_idx_nxt;
            gap_cnt     <= gap_cnt_nxt;
            valid       <= valid_nxt;
            num         <= num_nxt;
            err         <= err_nxt;
            frames_sent <= frames_nxt;
        end
    end

    // Nibble storage; contents are only meaningful below nib_cnt, so no reset is needed.
    always_ff @(posedge clock) begin
        if (!reset && wr_en) begin
            buf_q[nib_cnt] <= nib_val;
        end
    end

endmodule
